// File: rtl/seq_multiplier_shift_add.sv
// Unsigned shift-add multiplier: one partial product per clock, W iterations per operation.
// Product is registered and presented with a one-cycle done pulse that can drive a write enable.
module seq_multiplier_shift_add #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset_asynchronous,
  input  logic           start,
  input  logic [W-1:0]   multiplicand,
  input  logic [W-1:0]   multiplier,
  output logic [2*W-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [2*W-1:0] a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] product_q, product_d;

  always_ff @(posedge clk or posedge reset_asynchronous) begin
    if (reset_asynchronous) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = {{W{1'b0}}, multiplicand};
          b_d     = multiplier;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_q + (b_q[0] ? a_q : {2*W{1'b0}});
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CW'(1);
        // Last iteration: publish the accumulator including this cycle's partial product.
        if (cnt_q == CW'(W - 1)) begin
          product_d = acc_d;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign product = product_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: doc/seq_multiplier_shift_add.md
# seq_multiplier_shift_add

Unsigned sequential shift-add multiplier that sits directly upstream of the team's write-enabled result register. It accepts two W-bit operands on a start request and iterates one partial product per clock. It then presents a 2W-bit product with a one-cycle `done` pulse. That pulse connects straight to the downstream register's `write_enable`, and `product` connects to its `inp_reg`, which must be instantiated with width 2W.

## Interface
- `W`, default 4: operand width in bits; legal range 2..32.

- `clk`  input  1: rising-edge clock.
- `reset_asynchronous`  input  1: asynchronous, active-high reset; forces all state to reset values immediately.
- `start`  input  1: request to begin a multiplication; sampled only in IDLE.
- `multiplicand`  input  W: operand A, unsigned; sampled on the accepting edge.
- `multiplier`  input  W: operand B, unsigned; sampled on the accepting edge.
- `product`  output  2W: registered result; holds the last completed product.
- `busy`  output  1: high in CALC and DONE; low in IDLE.
- `done`  output  1: one-cycle pulse, high only in DONE; drives the downstream `write_enable`.

## Operation
- Reset values while `reset_asynchronous`=1: state IDLE, `product`=0, `busy`=0, `done`=0, internal shifted-A/shifted-B/accumulator/count all 0.
- All outputs are registered or decoded from state only (Moore). No combinational path runs from inputs to outputs.
- States and transitions:
  - IDLE, with `start`=1 at a rising edge: load the shifted-A register with `multiplicand` zero-extended to 2W. Load the shifted-B register with `multiplier`. Clear the accumulator and count. Go to CALC.
  - IDLE, with `start`=0: remain in IDLE.
  - CALC, at each rising edge: if shifted-B[0]=1, add shifted-A to the accumulator (2W-bit add, which cannot overflow). Then shift A left by 1 and shift B right by 1 logically, and increment count.
  - CALC, on the edge performing iteration W (count reaching W): write the final accumulator value into `product` and go to DONE.
  - DONE: unconditionally go to IDLE at the next rising edge.
- Count register width is clog2(W)+1.
- `start` in CALC or DONE is ignored; operand changes during CALC have no effect.
- `product` changes only on the CALC→DONE edge. It is stable for the whole DONE cycle and keeps its value until the next completion.
- Reset asserted mid-operation aborts the operation. No `done` is produced, and `product` returns to 0.
- Zero operands still take the full W iterations; there is no early termination.

## Timing
- Accepting edge: edge k, with `start`=1 in IDLE. `busy` goes high after edge k.
- CALC iterations occupy edges k+1 … k+W.
- After edge k+W, `done`=1 and `product` is valid for exactly one cycle.
- On edge k+W+1, the downstream register captures `product`. The multiplier returns to IDLE, with `busy`=0 and `done`=0.
- Start-to-done latency is W cycles. The minimum issue interval with `start` held high is W+2 cycles (next accept at edge k+W+2).
- Reset deassertion is expected synchronous to `clk`, at least one setup time before the next edge. The first possible accept is the first edge after deassertion.

## Test plan
- W=4, apply reset, then A=13, B=11, with a one-cycle `start` → `busy` rises next cycle; `done`=1 exactly 4 cycles after the accept edge, with `product`=143 (0x8F); the downstream register holds 0x8F afterwards.
- W=4, A=15, B=15 → `product`=225 (0xE1); then A=0, B=9 → `product`=0 after 4 cycles, with `done` still pulsing.
- W=4, `start` held high continuously with A=3, B=5 → `done` pulses every 6 cycles, each with `product`=15; `done` is never high for 2 consecutive cycles.
- W=4, accept A=6, B=7, then during CALC drive `start`=1 with A=2, B=2 → the extra `start` is ignored; the result is 42 and `busy` stays low for at least one cycle after DONE.
- W=4, accept A=9, B=9, assert `reset_asynchronous` between clock edges at CALC iteration 2 → `product`, `busy` and `done` go to 0 immediately without waiting for an edge; no `done` pulse follows. A subsequent A=2, B=3 yields 6.
- W=8, A=255, B=255 → `product`=65025 (0xFE01) with `done` 8 cycles after accept, exercising the full 2W width.
